// File: rtl/lfsr_ctrl_pkg.sv
// lfsr_ctrl_pkg: shared types and defaults for the LFSR cascade controller.
// Holds the controller FSM state enum and default STAGES / LIMIT_W values.
package lfsr_ctrl_pkg;

   localparam int STAGES_DEF  = 4;
   localparam int LIMIT_W_DEF = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_PAUSE,
      S_DONE,
      S_OVF
   } state_t;

endpackage

// File: rtl/lfsr_carry_chain.sv
// lfsr_carry_chain: ripple carry-enable for a cascade of stage counters.
// Ports: accept (base enable), carry[i] (stage i terminal),
//        cnt[i] (enable for stage i), wrap (whole cascade wraps).
module lfsr_carry_chain
   import lfsr_ctrl_pkg::*;
#(
   parameter int STAGES = STAGES_DEF
) (
   input  logic              accept,
   input  logic [STAGES-1:0] carry,
   output logic [STAGES-1:0] cnt,
   output logic              wrap
);

   // en[i] = accept & carry[0] & ... & carry[i-1]
   logic [STAGES:0] en;

   assign en[0] = accept;

   for (genvar i = 0; i < STAGES; i++) begin : g_chain
      assign en[i+1] = en[i] & carry[i];
   end

   assign cnt  = en[STAGES-1:0];
   assign wrap = en[STAGES];

endmodule

// File: rtl/lfsr_cascade_ctrl.sv
// lfsr_cascade_ctrl: run/pause/limit/overflow control for cascaded stages.
// Ports: Clk, Rst (sync, high), Start/Stop/Clear/Tick commands, Limit,
//        Carry in; CNT enables, Stage_Rst, Busy/Done/Ovf, Tick_Count out.
module lfsr_cascade_ctrl
   import lfsr_ctrl_pkg::*;
#(
   parameter int STAGES  = STAGES_DEF,
   parameter int LIMIT_W = LIMIT_W_DEF
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Start,
   input  logic               Stop,
   input  logic               Clear,
   input  logic               Tick,
   input  logic [LIMIT_W-1:0] Limit,
   input  logic [STAGES-1:0]  Carry,
   output logic [STAGES-1:0]  CNT,
   output logic               Stage_Rst,
   output logic               Busy,
   output logic               Done,
   output logic               Ovf,
   output logic [LIMIT_W-1:0] Tick_Count
);

   state_t             state;
   logic [LIMIT_W-1:0] limit_q;
   logic [LIMIT_W-1:0] count_q;
   logic [LIMIT_W-1:0] count_inc;
   logic               busy_q;
   logic               done_q;
   logic               ovf_q;
   logic               accept;
   logic               wrap;
   logic               hit;

   // Stop/Clear/Rst outrank a tick, so a tick under any of them is lost.
   assign accept = (state == S_RUN) & Tick & ~Stop & ~Clear & ~Rst;

   assign count_inc = count_q + LIMIT_W'(1);

   // Limit of zero means free-running: never reaches DONE.
   assign hit = (limit_q != '0) && (count_inc == limit_q);

   lfsr_carry_chain #(
      .STAGES (STAGES)
   ) u_chain (
      .accept (accept),
      .carry  (Carry),
      .cnt    (CNT),
      .wrap   (wrap)
   );

   assign Stage_Rst  = Rst | Clear;
   assign Busy       = busy_q;
   assign Done       = done_q;
   assign Ovf        = ovf_q;
   assign Tick_Count = count_q;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state   <= S_IDLE;
         count_q <= '0;
         limit_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (Clear) begin
         state   <= S_IDLE;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (!Stop && Start) begin
                  state   <= S_RUN;
                  limit_q <= Limit;
                  count_q <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_RUN: begin
               if (Stop) begin
                  state <= S_PAUSE;
               end else if (accept) begin
                  count_q <= count_inc;
                  // Overflow wins over a coincident limit hit.
                  if (wrap) begin
                     state  <= S_OVF;
                     busy_q <= 1'b0;
                     ovf_q  <= 1'b1;
                  end else if (hit) begin
                     state  <= S_DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end
               end
            end
            S_PAUSE: begin
               if (!Stop && Start) begin
                  state <= S_RUN;
               end
            end
            S_DONE, S_OVF: begin
               state <= state;
            end
            default: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
               ovf_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_cascade_ctrl.sv
// tb_lfsr_cascade_ctrl: self-checking bench, two 8-state stage models.
// Directed scenarios plus random stimulus against a tick-count model.
module tb_lfsr_cascade_ctrl;

   localparam int ST = 2;
   localparam int LW = 16;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;
   localparam int M_OVF   = 4;

   logic          Clk = 1'b0;
   logic          Rst = 1'b1;
   logic          Start = 1'b0;
   logic          Stop = 1'b0;
   logic          Clear = 1'b0;
   logic          Tick = 1'b0;
   logic [LW-1:0] Limit = '0;
   logic [ST-1:0] Carry;
   logic [ST-1:0] CNT;
   logic          Stage_Rst;
   logic          Busy;
   logic          Done;
   logic          Ovf;
   logic [LW-1:0] Tick_Count;

   int vectors = 0;
   int miscompares = 0;

   // model: mode, accepted ticks since Start, latched limit,
   // accepted ticks since last stage reset (cascade position)
   int m_mode = M_IDLE;
   int m_cnt = 0;
   int m_lim = 0;
   int m_pos = 0;

   always #5 Clk = ~Clk;

   lfsr_cascade_ctrl #(
      .STAGES  (ST),
      .LIMIT_W (LW)
   ) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .Start      (Start),
      .Stop       (Stop),
      .Clear      (Clear),
      .Tick       (Tick),
      .Limit      (Limit),
      .Carry      (Carry),
      .CNT        (CNT),
      .Stage_Rst  (Stage_Rst),
      .Busy       (Busy),
      .Done       (Done),
      .Ovf        (Ovf),
      .Tick_Count (Tick_Count)
   );

   // behavioural 8-state stage counters driven by the controller
   logic [2:0] sq [ST];
   initial for (int i = 0; i < ST; i++) sq[i] = 3'd0;

   always @(posedge Clk) begin
      for (int i = 0; i < ST; i++) begin
         if (Stage_Rst) sq[i] <= 3'd0;
         else if (CNT[i]) sq[i] <= sq[i] + 3'd1;
      end
   end

   always_comb begin
      Carry = '0;
      for (int i = 0; i < ST; i++) Carry[i] = (sq[i] == 3'd7);
   end

   function automatic logic m_acc();
      return (m_mode == M_RUN) && Tick && !Stop && !Clear && !Rst;
   endfunction

   function automatic logic [1:0] exp_cnt();
      logic a;
      a = m_acc();
      return {a && (m_pos % 8 == 7), a};
   endfunction

   task automatic drive(input logic r, s, p, c, t,
                        input logic [LW-1:0] l);
      @(negedge Clk);
      Rst = r; Start = s; Stop = p; Clear = c; Tick = t; Limit = l;
      #1;
   endtask

   // advance the model with the current inputs, then clock the DUT
   task automatic commit();
      logic a;
      a = m_acc();
      if (Rst) begin
         m_mode = M_IDLE; m_cnt = 0; m_lim = 0; m_pos = 0;
      end else if (Clear) begin
         m_mode = M_IDLE; m_cnt = 0; m_pos = 0;
      end else if (m_mode == M_IDLE) begin
         if (!Stop && Start) begin
            m_mode = M_RUN; m_lim = int'(Limit); m_cnt = 0;
         end
      end else if (m_mode == M_RUN) begin
         if (Stop) m_mode = M_PAUSE;
         else if (a) begin
            m_cnt = (m_cnt + 1) % 65536;
            m_pos = (m_pos + 1) % 64;
            if (m_pos == 0) m_mode = M_OVF;
            else if (m_lim != 0 && m_cnt == m_lim) m_mode = M_DONE;
         end
      end else if (m_mode == M_PAUSE) begin
         if (!Stop && Start) m_mode = M_RUN;
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic do_clear();
      drive(0, 0, 0, 1, 0, '0);
      vectors++;
      if (Stage_Rst !== 1'b1 || CNT !== 2'b00) begin
         miscompares++;
         $display("FAIL clear_cycle: srst=%b cnt=%b want 1/00",
                  Stage_Rst, CNT);
      end
      commit();
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 1, '0);
      vectors++;
      if (Stage_Rst !== 1'b1 || CNT !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_comb: srst=%b cnt=%b want 1/00",
                  Stage_Rst, CNT);
      end
      commit();
      drive(0, 0, 0, 0, 0, '0);
      vectors++;
      if (Stage_Rst !== 1'b0 || CNT !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_idle_comb: srst=%b cnt=%b want 0/00",
                  Stage_Rst, CNT);
      end
      commit();
      vectors++;
      if (Busy !== 1'b0 || Done !== 1'b0 || Ovf !== 1'b0 ||
          Tick_Count !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_regs: b=%b d=%b o=%b tc=%0d want 0/0/0/0",
                  Busy, Done, Ovf, Tick_Count);
      end
   endtask

   task automatic test_limit();
      do_clear();
      drive(0, 1, 0, 0, 0, 16'd5);
      commit();
      for (int k = 1; k <= 7; k++) begin
         drive(0, 0, 0, 0, 1, 16'd9);
         vectors++;
         if (CNT !== ((k <= 5) ? 2'b01 : 2'b00)) begin
            miscompares++;
            $display("FAIL limit_cnt tick %0d: cnt=%b", k, CNT);
         end
         commit();
      end
      vectors++;
      if (Tick_Count !== 16'd5 || Done !== 1'b1 || Ovf !== 1'b0 ||
          Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL limit_done: tc=%0d d=%b o=%b b=%b want 5/1/0/0",
                  Tick_Count, Done, Ovf, Busy);
      end
   endtask

   task automatic test_overflow(input logic [LW-1:0] lim);
      int pulses;
      pulses = 0;
      do_clear();
      drive(0, 1, 0, 0, 0, lim);
      commit();
      for (int k = 1; k <= 64; k++) begin
         drive(0, 0, 0, 0, 1, '0);
         vectors++;
         if (CNT !== {(k % 8 == 0), 1'b1}) begin
            miscompares++;
            $display("FAIL ovf_cnt lim %0d tick %0d: cnt=%b",
                     lim, k, CNT);
         end
         if (CNT[1]) pulses++;
         commit();
         if (k < 64) begin
            vectors++;
            if (Busy !== 1'b1 || Ovf !== 1'b0 || Done !== 1'b0) begin
               miscompares++;
               $display("FAIL ovf_early tick %0d: b=%b o=%b d=%b",
                        k, Busy, Ovf, Done);
            end
         end
      end
      vectors++;
      if (Ovf !== 1'b1 || Done !== 1'b0 || Tick_Count !== 16'd64 ||
          Busy !== 1'b0 || pulses != 8) begin
         miscompares++;
         $display("FAIL ovf_end lim %0d: o=%b d=%b tc=%0d p=%0d",
                  lim, Ovf, Done, Tick_Count, pulses);
      end
   endtask

   task automatic test_pause();
      do_clear();
      drive(0, 1, 0, 0, 0, '0);
      commit();
      for (int k = 0; k < 9; k++) begin
         case (k)
            3:       drive(0, 0, 1, 0, 1, '0);
            4, 5:    drive(0, 0, 0, 0, 1, '0);
            6:       drive(0, 1, 0, 0, 0, '0);
            default: drive(0, 0, 0, 0, 1, '0);
         endcase
         vectors++;
         if (CNT !== ((k >= 3 && k <= 6) ? 2'b00 : 2'b01)) begin
            miscompares++;
            $display("FAIL pause_cnt step %0d: cnt=%b", k, CNT);
         end
         commit();
         vectors++;
         if (Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pause_busy step %0d: busy=%b want 1",
                     k, Busy);
         end
      end
      vectors++;
      if (Tick_Count !== 16'd5) begin
         miscompares++;
         $display("FAIL pause_count: tc=%0d want 5", Tick_Count);
      end
   endtask

   task automatic test_clear_mid();
      do_clear();
      drive(0, 1, 0, 0, 0, '0);
      commit();
      for (int k = 0; k < 9; k++) begin
         drive(0, 0, 0, 0, 1, '0);
         commit();
      end
      vectors++;
      if (Tick_Count !== 16'd9) begin
         miscompares++;
         $display("FAIL clear_pre: tc=%0d want 9", Tick_Count);
      end
      drive(0, 1, 0, 1, 1, '0);
      vectors++;
      if (Stage_Rst !== 1'b1 || CNT !== 2'b00) begin
         miscompares++;
         $display("FAIL clear_mid_comb: srst=%b cnt=%b want 1/00",
                  Stage_Rst, CNT);
      end
      commit();
      drive(0, 0, 0, 0, 1, '0);
      vectors++;
      if (Busy !== 1'b0 || Tick_Count !== 16'd0 || CNT !== 2'b00) begin
         miscompares++;
         $display("FAIL clear_mid_idle: b=%b tc=%0d cnt=%b",
                  Busy, Tick_Count, CNT);
      end
      commit();
   endtask

   task automatic test_rst_mid();
      drive(0, 1, 0, 0, 0, '0);
      commit();
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 0, 1, '0);
         commit();
      end
      drive(1, 1, 0, 0, 1, '0);
      vectors++;
      if (Stage_Rst !== 1'b1 || CNT !== 2'b00) begin
         miscompares++;
         $display("FAIL rst_mid_comb: srst=%b cnt=%b", Stage_Rst, CNT);
      end
      commit();
      vectors++;
      if (Busy !== 1'b0 || Tick_Count !== 16'd0 || Done !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_regs: b=%b tc=%0d d=%b",
                  Busy, Tick_Count, Done);
      end
   endtask

   task automatic test_random(input int n);
      logic [LW-1:0] l;
      for (int k = 0; k < n; k++) begin
         l = ($urandom_range(0, 3) == 0) ? '0 : LW'($urandom_range(1, 12));
         drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 15,
               $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 2,
               $urandom_range(0, 99) < 75, l);
         vectors++;
         if (CNT !== exp_cnt() || Stage_Rst !== (Rst | Clear)) begin
            miscompares++;
            $display("FAIL rand_comb %0d: cnt=%b srst=%b want %b/%b",
                     k, CNT, Stage_Rst, exp_cnt(), Rst | Clear);
         end
         commit();
         vectors++;
         if (Busy !== (m_mode == M_RUN || m_mode == M_PAUSE) ||
             Done !== (m_mode == M_DONE) || Ovf !== (m_mode == M_OVF) ||
             Tick_Count !== LW'(m_cnt)) begin
            miscompares++;
            $display("FAIL rand_regs %0d: b=%b d=%b o=%b tc=%0d mode=%0d cnt=%0d",
                     k, Busy, Done, Ovf, Tick_Count, m_mode, m_cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_limit();
      test_overflow(16'd0);
      test_overflow(16'd64);
      test_pause();
      test_clear_mid();
      test_rst_mid();
      test_random(1500);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lfsr_cascade_ctrl.md
LFSR_CASCADE_CTRL -- requirements
Module: lfsr_cascade_ctrl

Interface
REQ-001 Parameter STAGES, default 4, number of cascaded state-extended LFSR stage counters controlled.
REQ-002 Parameter LIMIT_W, default 16, width of tick limit and tick counter.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 Start  input  1  begin/resume counting.
REQ-006 Stop  input  1  pause counting.
REQ-007 Clear  input  1  abort; return to IDLE and reset stages.
REQ-008 Tick  input  1  count event, one per cycle max.
REQ-009 Limit  input  LIMIT_W  ticks to accept before DONE; 0 = free-running.
REQ-010 Carry  input  STAGES  Carry[i] high while stage i is in its terminal state.
REQ-011 CNT  output  STAGES  per-stage count enable, combinational.
REQ-012 Stage_Rst  output  1  active-high stage reset, combinational.
REQ-013 Busy  output  1  high in RUN or PAUSE.
REQ-014 Done  output  1  sticky, limit reached.
REQ-015 Ovf  output  1  sticky, whole cascade wrapped.
REQ-016 Tick_Count  output  LIMIT_W  accepted ticks since Start from IDLE.

Function
REQ-017 FSM states: IDLE, RUN, PAUSE, DONE, OVF.
REQ-018 Priority per cycle: Rst > Clear > Stop > Start > Tick.
REQ-019 IDLE + Start -> RUN; Limit latched into Limit_q; Tick_Count <= 0.
REQ-020 accept = (state==RUN) & Tick & ~Stop & ~Clear & ~Rst.
REQ-021 CNT[0] = accept; CNT[i] = accept & Carry[0] & ... & Carry[i-1] (ripple carry-enable).
REQ-022 Each accepted tick increments Tick_Count by 1, modulo 2^LIMIT_W, no flag on wrap.
REQ-023 RUN + accept with all Carry high -> OVF, Ovf <= 1 next cycle; the stages wrap on that same edge.
REQ-024 RUN + accept with Limit_q != 0 and Tick_Count+1 == Limit_q -> DONE, Done <= 1; if REQ-023 holds in the same cycle, OVF wins and Done stays 0.
REQ-025 RUN + Stop -> PAUSE; a Tick in the same cycle is not accepted.
REQ-026 PAUSE + Start -> RUN with Tick_Count and Limit_q kept; Stop in PAUSE is ignored.
REQ-027 Start in RUN, DONE or OVF is ignored; Limit changes after latch have no effect.
REQ-028 DONE and OVF hold with CNT=0 until Clear; Ticks in these states are dropped.
REQ-029 Clear in any state -> IDLE, Tick_Count <= 0, Done <= 0, Ovf <= 0; Stage_Rst = 1 and CNT = 0 in that cycle.
REQ-030 Stage_Rst = Rst | Clear; it has no other source.
REQ-031 Busy, Done and Ovf are registered and decoded from state; latency is 1 cycle after the triggering edge.

Reset
REQ-032 On Rst edge: state IDLE, Tick_Count=0, Limit_q=0, Done=0, Ovf=0, Busy=0.
REQ-033 While Rst is high: CNT=0 and Stage_Rst=1; Rst mid-RUN discards all progress, identical to power-up.

Structure
REQ-034 Package lfsr_ctrl_pkg holds the FSM state enum and the default values of STAGES and LIMIT_W.
REQ-035 Sub-module lfsr_carry_chain computes the prefix-AND enables of REQ-021 from accept and Carry.

Verification (bench uses behavioural 8-state stage models, STAGES=2)
REQ-036 Rst 1 cycle, then idle -> CNT=0, Stage_Rst=1 only during reset, Busy/Done/Ovf=0, Tick_Count=0.
REQ-037 Limit=5, Start, 7 Ticks -> Tick_Count=5, Done=1, state DONE, CNT=0 for ticks 6-7.
REQ-038 Limit=0, Start, 64 Ticks -> CNT[1] pulses on ticks 8,16,...,64; tick 64 sets Ovf=1, Done=0, Tick_Count=64.
REQ-039 Limit=64, 64 Ticks -> simultaneous overflow and limit; Ovf=1, Done=0.
REQ-040 Start, 3 Ticks, Stop+Tick same cycle, 2 Ticks, Start, 2 Ticks -> Tick_Count=5, Busy=1 throughout.
REQ-041 Clear+Start+Tick same cycle while in RUN at Tick_Count=9 -> IDLE, Tick_Count=0, Stage_Rst=1 that cycle, CNT=0.
